pat_serializer: RTL

//  Serial pattern generator: the transmit side of the serial pattern detectors.

---
 rtl/pat_serializer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/pat_serializer.sv
// Serial pattern generator: shifts a latched pattern out MSB-first, REPS times with idle gaps.
// Optional PATSER_PRBS_FILL_EN fills gap cycles with PRBS7 instead of constant 0.
module pat_serializer #(
    parameter int SIZE = 5,
    parameter int REPW = 4,
    parameter int GAPW = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [SIZE-1:0] pat,
    input  logic [REPW-1:0] reps,
    input  logic [GAPW-1:0] gap,
    input  logic            abort,
    output logic            out,
    output logic            out_valid,
    output logic            busy,
    output logic            done
);

    localparam int BW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [BW-1:0] LAST_IDX = BW'(SIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP
    } state_e;

    state_e          state_q, state_d;
    logic [SIZE-1:0] pat_q, pat_d;
    logic [SIZE-1:0] sh_q, sh_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [REPW-1:0] frm_q, frm_d;
    logic [GAPW-1:0] gapl_q, gapl_d;
    logic [GAPW-1:0] gcnt_q, gcnt_d;
    logic            out_q, out_d;
    logic            vld_q, vld_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            load_frame;
    logic            fill_adv;
    logic            fill_bit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pat_q   <= '0;
            sh_q    <= '0;
            bit_q   <= '0;
            frm_q   <= '0;
            gapl_q  <= '0;
            gcnt_q  <= '0;
            out_q   <= 1'b0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            sh_q    <= sh_d;
            bit_q   <= bit_d;
            frm_q   <= frm_d;
            gapl_q  <= gapl_d;
            gcnt_q  <= gcnt_d;
            out_q   <= out_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pat_d      = pat_q;
        sh_d       = sh_q;
        bit_d      = bit_q;
        frm_d      = frm_q;
        gapl_d     = gapl_q;
        gcnt_d     = gcnt_q;
        out_d      = out_q;
        vld_d      = vld_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        load_frame = 1'b0;
        fill_adv   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                out_d  = 1'b0;
                vld_d  = 1'b0;
                busy_d = 1'b0;
                if (start && !abort) begin
                    pat_d   = pat;
                    sh_d    = {pat[SIZE-2:0], 1'b0};
                    bit_d   = LAST_IDX;
                    frm_d   = (reps == '0) ? REPW'(1) : reps;
                    gapl_d  = gap;
                    out_d   = pat[SIZE-1];
                    vld_d   = 1'b1;
                    busy_d  = 1'b1;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (bit_q != '0) begin
                    out_d = sh_q[SIZE-1];
                    sh_d  = {sh_q[SIZE-2:0], 1'b0};
                    bit_d = bit_q - 1'b1;
                end else if (frm_q == REPW'(1)) begin
                    // last bit of last frame: one-cycle done, back to idle
                    frm_d   = '0;
                    out_d   = 1'b0;
                    vld_d   = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    frm_d = frm_q - 1'b1;
                    if (gapl_q != '0) begin
                        gcnt_d   = gapl_q;
                        out_d    = fill_bit;
                        vld_d    = 1'b0;
                        fill_adv = 1'b1;
                        state_d  = S_GAP;
                    end else begin
                        load_frame = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (gcnt_q == GAPW'(1)) begin
                    load_frame = 1'b1;
                end else begin
                    gcnt_d   = gcnt_q - 1'b1;
                    out_d    = fill_bit;
                    fill_adv = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                out_d   = 1'b0;
                vld_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        if (load_frame) begin
            sh_d    = {pat_q[SIZE-2:0], 1'b0};
            bit_d   = LAST_IDX;
            out_d   = pat_q[SIZE-1];
            vld_d   = 1'b1;
            state_d = S_SEND;
        end

        // cancel wins over everything, no done pulse
        if (abort && state_q != S_IDLE) begin
            state_d  = S_IDLE;
            bit_d    = '0;
            frm_d    = '0;
            gcnt_d   = '0;
            out_d    = 1'b0;
            vld_d    = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            fill_adv = 1'b0;
        end
    end

`ifdef PATSER_PRBS_FILL_EN
    logic [6:0] lfsr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= 7'h7F;
        end else if (fill_adv) begin
            lfsr_q <= {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
        end
    end

    assign fill_bit = lfsr_q[6];
`else
    logic adv_unused;

    assign adv_unused = fill_adv;
    assign fill_bit   = 1'b0;
`endif

    assign out       = out_q;
    assign out_valid = vld_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
